// File: rtl/nco_sweep_ctrl_pkg.sv
// nco_sweep_pkg: shared types and defaults for the NCO frequency-sweep controller.
//   FTW_W_DEF / DWELL_W_DEF : default FTW and dwell-counter widths
//   sweep_mode_e            : SINGLE, SAW, TRI
//   sweep_state_e           : IDLE, UP, DOWN
//   ftw_sel_e               : source select for the next FTW load
package nco_sweep_pkg;

   localparam int unsigned FTW_W_DEF   = 32;
   localparam int unsigned DWELL_W_DEF = 16;

   typedef enum logic [1:0] {
      SINGLE = 2'b00,
      SAW    = 2'b01,
      TRI    = 2'b10
   } sweep_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      UP,
      DOWN
   } sweep_state_e;

   typedef enum logic [2:0] {
      SEL_CFG_START,   // start word straight from the request inputs
      SEL_START,       // latched start word
      SEL_STOP,        // latched stop word
      SEL_SUM,         // ftw + step
      SEL_DIFF         // ftw - step
   } ftw_sel_e;

   // The unused mode code 2'b11 behaves as single-shot.
   function automatic sweep_mode_e decode_mode(input logic [1:0] m);
      return (m == 2'b11) ? SINGLE : sweep_mode_e'(m);
   endfunction

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// nco_sweep_ctrl_if: request/configuration and FTW output bundle of the sweep controller.
//   master : drives start, abort, mode, start_ftw, stop_ftw, step_ftw, dwell;
//            receives ftw_out, ftw_upd, busy, done, cfg_err, phase_clr
//   slave  : the controller side (directions reversed)
interface nco_sweep_ctrl_if
   import nco_sweep_pkg::*;
#(
   parameter int unsigned FTW_W   = FTW_W_DEF,
   parameter int unsigned DWELL_W = DWELL_W_DEF
) ();

   logic               start;
   logic               abort;
   logic [1:0]         mode;
   logic [FTW_W-1:0]   start_ftw;
   logic [FTW_W-1:0]   stop_ftw;
   logic [FTW_W-1:0]   step_ftw;
   logic [DWELL_W-1:0] dwell;
   logic [FTW_W-1:0]   ftw_out;
   logic               ftw_upd;
   logic               busy;
   logic               done;
   logic               cfg_err;
   logic               phase_clr;

   modport master (
      output start, abort, mode, start_ftw, stop_ftw, step_ftw, dwell,
      input  ftw_out, ftw_upd, busy, done, cfg_err, phase_clr
   );

   modport slave (
      input  start, abort, mode, start_ftw, stop_ftw, step_ftw, dwell,
      output ftw_out, ftw_upd, busy, done, cfg_err, phase_clr
   );

endinterface

// File: rtl/nco_sweep_ctrl_dwell_timer.sv
// nco_dwell_timer: loadable dwell down-counter.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   load, load_val   : (re)start the count; expire follows load_val+1 cycles later
//   clear            : stop the timer without expiring
//   expire           : one-cycle pulse when the dwell period has elapsed
module nco_dwell_timer #(
   parameter int unsigned DWELL_W = 16
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               load,
   input  logic               clear,
   input  logic [DWELL_W-1:0] load_val,
   output logic               expire
);

   logic [DWELL_W-1:0] cnt_q;
   logic               run_q;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (load) begin
         cnt_q <= load_val;
         run_q <= 1'b1;
      end else if (clear) begin
         run_q <= 1'b0;
      end else if (run_q && (cnt_q != '0)) begin
         cnt_q <= cnt_q - DWELL_W'(1);
      end
   end

   // The owner reloads or clears on every expire, so this stays a single-cycle pulse.
   assign expire = run_q && (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: linear FTW sweep generator feeding the NCO.
//   sys_clk, sys_rst : 50 MHz clock, asynchronous active-high reset
//   bus (slave)      : start/abort request, sweep configuration, ftw_out/ftw_upd,
//                      busy, done, cfg_err, phase_clr
// Optional feature macro: NCO_SWEEP_PHASE_CLR_EN -- phase_clr pulses on every
// load of the start word; without it phase_clr is tied low.
module nco_sweep_ctrl
   import nco_sweep_pkg::*;
#(
   parameter int unsigned FTW_W   = FTW_W_DEF,
   parameter int unsigned DWELL_W = DWELL_W_DEF
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   nco_sweep_ctrl_if.slave  bus
);

   sweep_state_e       state_q, state_nxt;
   sweep_mode_e        mode_q;
   logic [FTW_W-1:0]   start_q, stop_q, step_q, ftw_q, ftw_nxt;
   logic [DWELL_W-1:0] dwell_q;
   logic [FTW_W:0]     sum, diff;
   logic               up_hit, dn_hit, at_stop, cfg_ok, expire;
   logic               ld, done_set, err_set, cfg_latch, tmr_load, tmr_clear;
   ftw_sel_e           sel;
   logic               upd_q, done_q, err_q;

   // One extra bit catches carry on the way up and borrow on the way down.
   assign sum     = {1'b0, ftw_q} + {1'b0, step_q};
   assign diff    = {1'b0, ftw_q} - {1'b0, step_q};
   assign up_hit  = sum[FTW_W] || (sum[FTW_W-1:0] >= stop_q);
   assign dn_hit  = diff[FTW_W] || (diff[FTW_W-1:0] <= start_q);
   assign at_stop = (ftw_q == stop_q);
   assign cfg_ok  = (bus.step_ftw != '0) && (bus.start_ftw <= bus.stop_ftw);

   nco_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .load     (tmr_load),
      .clear    (tmr_clear),
      .load_val (cfg_latch ? bus.dwell : dwell_q),
      .expire   (expire)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= IDLE;
      else         state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE: if (bus.start && !bus.abort && cfg_ok) state_nxt = UP;
         UP: begin
            if (bus.abort) begin
               state_nxt = IDLE;
            end else if (expire && at_stop) begin
               case (mode_q)
                  SAW:     state_nxt = UP;
                  TRI:     state_nxt = dn_hit ? UP : DOWN;
                  default: state_nxt = IDLE;
               endcase
            end
         end
         DOWN: begin
            if (bus.abort)             state_nxt = IDLE;
            else if (expire && dn_hit) state_nxt = UP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ld        = 1'b0;
      sel       = SEL_SUM;
      done_set  = 1'b0;
      err_set   = 1'b0;
      cfg_latch = 1'b0;
      tmr_load  = 1'b0;
      tmr_clear = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               if (cfg_ok) begin
                  cfg_latch = 1'b1;
                  ld        = 1'b1;
                  sel       = SEL_CFG_START;
                  tmr_load  = 1'b1;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         UP: begin
            if (bus.abort) begin
               tmr_clear = 1'b1;
            end else if (expire) begin
               if (at_stop) begin
                  case (mode_q)
                     SAW: begin
                        ld       = 1'b1;
                        sel      = SEL_START;
                        tmr_load = 1'b1;
                     end
                     // The top turnaround loads the first down value directly so
                     // stop is not repeated; a step that undershoots start bounces
                     // straight back to start.
                     TRI: begin
                        ld       = 1'b1;
                        sel      = dn_hit ? SEL_START : SEL_DIFF;
                        tmr_load = 1'b1;
                     end
                     default: begin
                        done_set  = 1'b1;
                        tmr_clear = 1'b1;
                     end
                  endcase
               end else begin
                  ld       = 1'b1;
                  sel      = up_hit ? SEL_STOP : SEL_SUM;
                  tmr_load = 1'b1;
               end
            end
         end
         DOWN: begin
            if (bus.abort) begin
               tmr_clear = 1'b1;
            end else if (expire) begin
               ld       = 1'b1;
               sel      = dn_hit ? SEL_START : SEL_DIFF;
               tmr_load = 1'b1;
            end
         end
         default: tmr_clear = 1'b1;
      endcase
   end

   always_comb begin
      case (sel)
         SEL_CFG_START: ftw_nxt = bus.start_ftw;
         SEL_START:     ftw_nxt = start_q;
         SEL_STOP:      ftw_nxt = stop_q;
         SEL_DIFF:      ftw_nxt = diff[FTW_W-1:0];
         default:       ftw_nxt = sum[FTW_W-1:0];
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         mode_q  <= SINGLE;
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         dwell_q <= '0;
         ftw_q   <= '0;
         upd_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (cfg_latch) begin
            mode_q  <= decode_mode(bus.mode);
            start_q <= bus.start_ftw;
            stop_q  <= bus.stop_ftw;
            step_q  <= bus.step_ftw;
            dwell_q <= bus.dwell;
         end
         if (ld) ftw_q <= ftw_nxt;
         upd_q  <= ld;
         done_q <= done_set;
         err_q  <= err_set;
      end
   end

`ifdef NCO_SWEEP_PHASE_CLR_EN
   logic pclr_q;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) pclr_q <= 1'b0;
      else         pclr_q <= ld && ((sel == SEL_CFG_START) || (sel == SEL_START));
   end

   assign bus.phase_clr = pclr_q;
`else
   assign bus.phase_clr = 1'b0;
`endif

   assign bus.ftw_out = ftw_q;
   assign bus.ftw_upd = upd_q;
   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = done_q;
   assign bus.cfg_err = err_q;

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep controller that sits directly upstream of the NCO and drives its frequency tuning word (FTW). On a start request it latches a sweep configuration and steps the FTW linearly from a start word to a stop word, holding each word for a programmable dwell. It supports single-shot, sawtooth-repeat and triangle-repeat modes. The NCO consumes `ftw_out` and produces the `da_data` samples.

## Interface
- `FTW_W`, 32: FTW width in bits.
- `DWELL_W`, 16: dwell counter width in bits.

- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle sweep request. Accepted only in IDLE.
- `abort`  in  1  stops the sweep in progress.
- `mode`  in  2  00 single, 01 sawtooth, 10 triangle, 11 treated as 00.
- `start_ftw`  in  FTW_W  first FTW of the sweep.
- `stop_ftw`  in  FTW_W  last FTW of the sweep.
- `step_ftw`  in  FTW_W  increment per step.
- `dwell`  in  DWELL_W  each FTW is held for dwell+1 cycles.
- `ftw_out`  out  FTW_W  FTW delivered to the NCO.
- `ftw_upd`  out  1  pulses for one cycle whenever `ftw_out` is loaded.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  one-cycle pulse at the end of a single-shot sweep.
- `cfg_err`  out  1  one-cycle pulse when a start request is rejected.
- `phase_clr`  out  1  see Configuration.

## Operation
- States: IDLE, UP, DOWN.
- Reset values: every output is 0, state is IDLE and the direction flag is "up".
- Start handling in IDLE:
  - The request is rejected when `step_ftw`==0 or `start_ftw`>`stop_ftw`. The state stays IDLE and `cfg_err` pulses.
  - Otherwise `mode`, `start_ftw`, `stop_ftw`, `step_ftw` and `dwell` are latched, `ftw_out` is loaded with `start_ftw` and the state becomes UP. Inputs are not sampled again until the next IDLE.
- UP step:
  - Compute next = ftw + step with an FTW_W+1-bit sum.
  - If there is a carry or next ≥ stop, load stop. Stop is therefore always emitted exactly once.
  - Holding stop is the end of the leg:
    - single: go to IDLE and pulse `done`.
    - sawtooth: reload start and stay in UP.
    - triangle: go to DOWN.
- DOWN step:
  - Compute next = ftw − step with a borrow.
  - If there is a borrow or next ≤ start, load start and return to UP.
  - At each turnaround the endpoint value appears once and is held for one dwell period.
- Degenerate case: start_ftw == stop_ftw.
  - single: one dwell period, then `done`.
  - sawtooth and triangle: the value is held and `ftw_upd` pulses every dwell period.
- `abort` in UP or DOWN: next state IDLE. `ftw_out` holds its current value and `done` does not pulse.
- `start` while busy is ignored and does not raise `cfg_err`.
- `abort` and `start` asserted together in IDLE: abort wins, nothing starts and there is no `cfg_err`.

## Timing
- Start accepted at edge N: `ftw_out`=start_ftw, `ftw_upd`=1 and `busy`=1 are visible after edge N.
- Each FTW value is held for exactly dwell+1 cycles. Consecutive `ftw_upd` pulses are therefore dwell+1 cycles apart, and with dwell=0 `ftw_upd` is high every cycle.
- Single mode end: `done` pulses and `busy` falls together, dwell+1 cycles after stop was loaded. A new `start` is accepted in the following cycle.
- Abort at edge M: `busy`=0 after edge M.
- Reset asserted mid-sweep: all outputs go to 0 immediately (asynchronous).
- Latency from a load to `ftw_out` is 0 cycles after the registering edge. `ftw_out` is a registered output.

## Configuration
- Macro `NCO_SWEEP_PHASE_CLR_EN`.
- Defined: `phase_clr` pulses together with `ftw_upd` on every load of `start_ftw`. That covers the initial start, each sawtooth reload and each triangle bottom turnaround. The NCO uses this pulse to zero its phase accumulator.
- Undefined: `phase_clr` is tied to 0 and no extra logic is generated.

## Structure
- Package `nco_sweep_pkg`:
  - `FTW_W` and `DWELL_W` defaults.
  - mode enum (SINGLE, SAW, TRI).
  - state enum (IDLE, UP, DOWN).
- Sub-module `nco_dwell_timer`:
  - Loadable down-counter with the same clock and reset.
  - Asserts a one-cycle `expire` each time dwell+1 cycles have elapsed since its load.
  - The controller FSM advances only on `expire`.

## Test plan
- Single sweep: start=100, stop=130, step=10, dwell=2 → `ftw_out` sequence 100, 110, 120, 130, each held 3 cycles. `done` pulses 3 cycles after 130 is loaded, and `busy` falls in the same cycle.
- Overshoot and overflow: start=100, stop=125, step=10 → 100, 110, 120, 125. Then start=0xFFFF_FFF0, stop=0xFFFF_FFFF, step=0x20 → 0xFFFF_FFF0, 0xFFFF_FFFF, with no wrap to small values.
- Triangle: start=0, stop=20, step=10, dwell=0 → repeating sequence 0, 10, 20, 10, 0, 10, 20, …, with `ftw_upd` high every cycle. Sawtooth with the same settings → 0, 10, 20, 0, 10, 20, …
- Rejects: step=0, and start=50 with stop=40 → `cfg_err` is a one-cycle pulse, `busy` stays 0 and `ftw_out` is unchanged. `start` while busy → ignored, no `cfg_err`.
- Abort and reset: abort while `ftw_out`=120 → `busy`=0 next cycle, `ftw_out` stays 120, no `done`. `sys_rst` pulsed mid-dwell → all outputs 0 without waiting for a clock edge. After release, a start is accepted normally.
- With `NCO_SWEEP_PHASE_CLR_EN` in sawtooth mode, start=0, stop=20, step=10: `phase_clr` coincides with each load of 0 and is 0 otherwise. Without the macro it is constant 0.
